// File: rtl/vec_packer_if.sv
// Bundles the word-stream input and the packed-vector output of vec_packer.
// Beat transfers when s_valid && s_ready; vector transfers when out_valid && next_ready.
interface vec_packer_if #(
    parameter int VEC_WIDTH  = 1100,
    parameter int WORD_WIDTH = 64
);
    logic [WORD_WIDTH-1:0] s_word;
    logic                  s_valid;
    logic                  s_last;
    logic                  s_ready;
    logic [VEC_WIDTH-1:0]  vec;
    logic                  out_valid;
    logic                  next_ready;
    logic                  len_err;

    modport master (
        output s_word, s_valid, s_last, next_ready,
        input  s_ready, vec, out_valid, len_err
    );

    modport slave (
        input  s_word, s_valid, s_last, next_ready,
        output s_ready, vec, out_valid, len_err
    );
endinterface

// File: rtl/vec_packer.sv
// Packs WORD_WIDTH-bit beats into a double-buffered VEC_WIDTH-bit vector.
// Optional VEC_PACKER_STATS_EN adds delivered-vector and framing-error counters.
module vec_packer #(
    parameter int VEC_WIDTH  = 1100,
    parameter int WORD_WIDTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    vec_packer_if.slave bus
`ifdef VEC_PACKER_STATS_EN
    ,
    output logic [31:0] vec_cnt,
    output logic [15:0] err_cnt
`endif
);
    localparam int BEATS      = (VEC_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int BCNT_WIDTH = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LAST_BITS  = VEC_WIDTH - (BEATS - 1) * WORD_WIDTH;
    localparam logic [BCNT_WIDTH-1:0] LAST_IDX = BCNT_WIDTH'(BEATS - 1);

    logic [BCNT_WIDTH-1:0] bcnt_q, bcnt_d;
    logic [VEC_WIDTH-1:0]  asm_buf_q, asm_buf_d;
    logic [VEC_WIDTH-1:0]  out_buf_q, out_buf_d;
    logic                  asm_full_q, asm_full_d;
    logic                  out_valid_q, out_valid_d;
    logic                  len_err_q, len_err_d;

    logic                  accept;
    logic                  out_can_load;
    logic                  last_beat;
    logic [VEC_WIDTH-1:0]  asm_written;

    assign bus.s_ready   = !asm_full_q && !rst;
    assign bus.vec       = out_buf_q;
    assign bus.out_valid = out_valid_q;
    assign bus.len_err   = len_err_q;

    assign accept       = bus.s_valid && bus.s_ready;
    assign out_can_load = !out_valid_q || bus.next_ready;
    assign last_beat    = (bcnt_q == LAST_IDX);

    // Current assembly contents with the incoming beat merged in at its slot.
    always_comb begin
        asm_written = asm_buf_q;
        for (int k = 0; k < BEATS - 1; k++) begin
            if (accept && bcnt_q == BCNT_WIDTH'(k)) begin
                asm_written[k*WORD_WIDTH +: WORD_WIDTH] = bus.s_word;
            end
        end
        if (accept && last_beat) begin
            asm_written[(BEATS-1)*WORD_WIDTH +: LAST_BITS] = bus.s_word[LAST_BITS-1:0];
        end
    end

    always_comb begin
        bcnt_d      = bcnt_q;
        asm_buf_d   = asm_buf_q;
        out_buf_d   = out_buf_q;
        asm_full_d  = asm_full_q;
        out_valid_d = out_valid_q;
        len_err_d   = 1'b0;

        if (out_valid_q && bus.next_ready) begin
            out_valid_d = 1'b0;
        end

        // A parked vector moves out as soon as the output slot frees up.
        if (asm_full_q && out_can_load) begin
            out_buf_d   = asm_buf_q;
            out_valid_d = 1'b1;
            asm_full_d  = 1'b0;
            asm_buf_d   = '0;
        end

        if (accept) begin
            if (bus.s_last || last_beat) begin
                bcnt_d    = '0;
                len_err_d = bus.s_last ^ last_beat;
                if (out_can_load) begin
                    out_buf_d   = asm_written;
                    out_valid_d = 1'b1;
                    asm_buf_d   = '0;
                end else begin
                    asm_buf_d  = asm_written;
                    asm_full_d = 1'b1;
                end
            end else begin
                bcnt_d    = bcnt_q + 1'b1;
                asm_buf_d = asm_written;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bcnt_q      <= '0;
            asm_buf_q   <= '0;
            out_buf_q   <= '0;
            asm_full_q  <= 1'b0;
            out_valid_q <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            asm_buf_q   <= asm_buf_d;
            out_buf_q   <= out_buf_d;
            asm_full_q  <= asm_full_d;
            out_valid_q <= out_valid_d;
            len_err_q   <= len_err_d;
        end
    end

`ifdef VEC_PACKER_STATS_EN
    logic [31:0] vec_cnt_q, vec_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        vec_cnt_d = vec_cnt_q;
        err_cnt_d = err_cnt_q;
        if (out_valid_q && bus.next_ready) begin
            vec_cnt_d = vec_cnt_q + 32'd1;
        end
        if (len_err_q && err_cnt_q != 16'hFFFF) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_cnt_q <= '0;
            err_cnt_q <= '0;
        end else begin
            vec_cnt_q <= vec_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign vec_cnt = vec_cnt_q;
    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_vec_packer.sv
// Scoreboard bench for vec_packer: the driver pushes expected vectors, the monitor pops on delivery.
module tb_vec_packer;
    localparam int VW    = 1100;
    localparam int WW    = 64;
    localparam int BEATS = (VW + WW - 1) / WW;

    logic clk;
    logic rst;

    vec_packer_if #(.VEC_WIDTH(VW), .WORD_WIDTH(WW)) bus ();

`ifdef VEC_PACKER_STATS_EN
    logic [31:0] vec_cnt;
    logic [15:0] err_cnt;
`endif

    vec_packer #(.VEC_WIDTH(VW), .WORD_WIDTH(WW)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave)
`ifdef VEC_PACKER_STATS_EN
        ,
        .vec_cnt (vec_cnt),
        .err_cnt (err_cnt)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    // scoreboard state
    logic [VW-1:0] exp_q[$];
    int n_checks   = 0;
    int n_fail     = 0;
    int n_deliv    = 0;
    int err_seen   = 0;
    int exp_err    = 0;
    bit rand_ready = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // monitor: samples 1 time unit after the falling edge, i.e. the values the next rising edge will see
    always begin
        logic [BEATS*WW-1:0] wo, we;
        @(negedge clk);
        #1;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.next_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_vec", 64'd1, 64'd0);
            end else begin
                wo = '0;
                we = '0;
                wo[VW-1:0] = bus.vec;
                we[VW-1:0] = exp_q.pop_front();
                for (int c = 0; c < BEATS; c++) begin
                    check($sformatf("vec%0d_w%0d", n_deliv, c), wo[c*WW +: WW], we[c*WW +: WW]);
                end
            end
            n_deliv++;
        end
        if (bus.len_err === 1'b1) err_seen++;
    end

    // driver tasks (all input changes at the falling edge)
    task automatic send_beat(input logic [WW-1:0] w, input logic l);
        int guard;
        guard = 0;
        bus.s_valid = 1'b1;
        bus.s_word  = w;
        bus.s_last  = l;
        while (bus.s_ready !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (rand_ready) bus.next_ready = 1'($urandom_range(0, 1));
        end
        if (bus.s_ready !== 1'b1) check("beat_accept_timeout", 64'(bus.s_ready), 64'd1);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        if (rand_ready) bus.next_ready = 1'($urandom_range(0, 1));
    endtask

    function automatic logic [WW-1:0] gen_word(input int mode, input int k);
        logic [3:0] k4;
        k4 = 4'(k);
        case (mode)
            0:       return {60'h0, k4};
            1:       return {WW{1'b1}};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // n beats; s_last on the final one when with_last. Pushes the expected vector first.
    task automatic send_vector(input int n, input int mode, input bit with_last);
        logic [WW-1:0]       words[BEATS];
        logic [BEATS*WW-1:0] wide;
        wide = '0;
        for (int k = 0; k < n; k++) begin
            words[k] = gen_word(mode, k);
            wide[k*WW +: WW] = words[k];
        end
        exp_q.push_back(wide[VW-1:0]);
        if ((with_last && n < BEATS) || (!with_last && n == BEATS)) exp_err++;
        for (int k = 0; k < n; k++) begin
            send_beat(words[k], with_last && (k == n - 1));
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        bus.next_ready = 1'b1;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("drain_remaining", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
    endtask

    initial begin
        int snap;
        rst            = 1'b1;
        bus.s_valid    = 1'b0;
        bus.s_last     = 1'b0;
        bus.s_word     = '0;
        bus.next_ready = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_len_err", 64'(bus.len_err), 64'd0);
        check("rst_s_ready", 64'(bus.s_ready), 64'd0);
        check("rst_vec_zero", 64'(|bus.vec), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 64'(bus.s_ready), 64'd1);

        // 1: correctly framed counting pattern, 1-cycle latency
        bus.next_ready = 1'b0;
        send_vector(BEATS, 0, 1);
        check("t1_latency_out_valid", 64'(bus.out_valid), 64'd1);
        check("t1_len_err", 64'(bus.len_err), 64'd0);
        check("t1_w5_low", 64'(bus.vec[5*64 +: 4]), 64'd5);
        check("t1_w16_low", 64'(bus.vec[16*64 +: 4]), 64'd0);
        check("t1_top12", 64'(bus.vec[1099:1088]), 64'h001);
        drain();

        // 2: all-ones, s_last on beat 4
        bus.next_ready = 1'b0;
        send_vector(5, 1, 1);
        check("t2_len_err", 64'(bus.len_err), 64'd1);
        check("t2_low_ones", 64'(&bus.vec[319:0]), 64'd1);
        check("t2_high_zero", 64'(|bus.vec[1099:320]), 64'd0);
        drain();

        // 3: back-to-back with downstream stalled
        bus.next_ready = 1'b0;
        send_vector(BEATS, 2, 1);
        send_vector(BEATS, 2, 1);
        repeat (2) @(negedge clk);
        check("t3_s_ready_blocked", 64'(bus.s_ready), 64'd0);
        check("t3_out_held", 64'(bus.out_valid), 64'd1);
        check("t3_out_is_first", bus.vec[63:0], exp_q[0][63:0]);
        bus.next_ready = 1'b1;
        @(negedge clk);
        check("t3_second_valid", 64'(bus.out_valid), 64'd1);
        check("t3_s_ready_back", 64'(bus.s_ready), 64'd1);
        check("t3_second_is_next", bus.vec[63:0], exp_q[0][63:0]);
        @(negedge clk);
        check("t3_out_idle", 64'(bus.out_valid), 64'd0);
        drain();

        // 4: missing s_last then a clean vector
        snap = n_deliv;
        bus.next_ready = 1'b1;
        send_vector(BEATS, 2, 0);
        check("t4_len_err_missing_last", 64'(bus.len_err), 64'd1);
        send_vector(BEATS, 0, 1);
        check("t4_len_err_clean", 64'(bus.len_err), 64'd0);
        drain();
        check("t4_vec_count", 64'(n_deliv - snap), 64'd2);

        // 5: reset with a held vector and a partial one
        bus.next_ready = 1'b0;
        send_vector(BEATS, 2, 1);
        for (int k = 0; k < 10; k++) send_beat({$urandom, $urandom}, 1'b0);
        check("t5_held_before_rst", 64'(bus.out_valid), 64'd1);
        pulse_reset();
        check("t5_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("t5_rst_vec_zero", 64'(|bus.vec), 64'd0);
        check("t5_rst_s_ready", 64'(bus.s_ready), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        send_vector(BEATS, 0, 1);
        check("t5_fresh_len_err", 64'(bus.len_err), 64'd0);
        drain();

        // random lengths under random downstream back-pressure
        rand_ready = 1;
        for (int i = 0; i < 8; i++) begin
            int n;
            n = $urandom_range(1, BEATS);
            send_vector(n, 2, (n < BEATS) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        rand_ready = 0;
        drain();

`ifdef VEC_PACKER_STATS_EN
        // 6: counters
        pulse_reset();
        check("t6_rst_vec_cnt", 64'(vec_cnt), 64'd0);
        check("t6_rst_err_cnt", 64'(err_cnt), 64'd0);
        rst = 1'b0;
        bus.next_ready = 1'b1;
        @(negedge clk);
        send_vector(5, 1, 1);
        send_vector(BEATS, 0, 1);
        drain();
        check("t6_vec_cnt", 64'(vec_cnt), 64'd2);
        check("t6_err_cnt", 64'(err_cnt), 64'd1);
`endif

        repeat (3) @(negedge clk);
        check("len_err_total", 64'(err_seen), 64'(exp_err));
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
